// File: rtl/ahb2_pkg.sv
// Shared AHB2 encodings and the slave FSM state type for the AHB2-to-SRAM bridge.
package ahb2_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_RD_WAIT,
        ST_RD_DATA,
        ST_ERR_1,
        ST_ERR_2
    } state_t;

    // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are no-ops.
    function automatic logic is_active_trans(input logic [1:0] trans);
        logic active;
        case (trans)
            HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
            default:                   active = 1'b0;
        endcase
        return active;
    endfunction

endpackage

// File: rtl/ahb2_be_gen.sv
// SRAM byte-enable generator: lane selection from transfer size and low address bits.
module ahb2_be_gen
    import ahb2_pkg::*;
(
    input  logic [2:0] i_hsize,
    input  logic [1:0] i_addr_lo,
    input  logic       i_write,
    output logic [3:0] o_be
);

    // Reads always fetch the full word; oversized writes fall back to a word.
    always_comb begin
        o_be = 4'b1111;
        if (i_write) begin
            case (i_hsize)
                HSIZE_BYTE: o_be = 4'b0001 << i_addr_lo;
                HSIZE_HALF: o_be = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                HSIZE_WORD: o_be = 4'b1111;
                default:    o_be = 4'b1111;
            endcase
        end
    end

endmodule

// File: rtl/ahb2_sram_slv.sv
// AHB2 slave bridging single transfers onto a synchronous 32-bit SRAM port.
// Optional error responses are enabled with the macro AHB2_SRAM_SLV_ERR_EN.
module ahb2_sram_slv
    import ahb2_pkg::*;
#(
    parameter int MEM_AW = 12
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              hsel,
    input  logic [31:0]       haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [3:0]        hprot,
    input  logic [31:0]       hwdata,
    input  logic              hreadyi,
    output logic [31:0]       hrdata,
    output logic              hreadyo,
    output logic [1:0]        hresp,
    output logic              sram_req,
    output logic              sram_we,
    output logic [MEM_AW-1:0] sram_addr,
    output logic [3:0]        sram_be,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    state_t            r_state;
    state_t            w_next;
    logic [MEM_AW-1:0] r_addr;
    logic [1:0]        r_lo;
    logic [2:0]        r_size;
    logic              r_write;
    logic [31:0]       r_hrdata;
    logic              w_accept;
    logic              w_err;
    logic [3:0]        w_be;
    logic              w_unused;

    // Burst type, protection and the upper address bits carry no meaning for a single flat SRAM.
    assign w_unused = ^{hburst, hprot, haddr[31:MEM_AW+2], HRESP_ERROR};

    // ERR_2 is excluded: the address presented there was sampled while hready was still low.
    assign w_accept = hsel && hreadyi && is_active_trans(htrans) &&
                      ((r_state == ST_IDLE) || (r_state == ST_WR_DATA) || (r_state == ST_RD_DATA));

`ifdef AHB2_SRAM_SLV_ERR_EN
    assign w_err = (hsize > HSIZE_WORD) ||
                   ((hsize == HSIZE_HALF) && haddr[0]) ||
                   ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00)) ||
                   (|haddr[31:MEM_AW+2]);
`else
    assign w_err = 1'b0;
`endif

    ahb2_be_gen u_be_gen (
        .i_hsize   (r_size),
        .i_addr_lo (r_lo),
        .i_write   (r_write),
        .o_be      (w_be)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_lo    <= 2'b00;
            r_size  <= 3'd0;
            r_write <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= haddr[MEM_AW+1:2];
            r_lo    <= haddr[1:0];
            r_size  <= hsize;
            r_write <= hwrite;
        end
    end

    // Read data is forwarded straight from the SRAM in RD_DATA and held afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hrdata <= 32'd0;
        end else if (r_state == ST_RD_DATA) begin
            r_hrdata <= sram_rdata;
        end
    end

    always_comb begin
        w_next   = ST_IDLE;
        hreadyo  = 1'b1;
        hresp    = HRESP_OKAY;
        sram_req = 1'b0;
        sram_we  = 1'b0;
        sram_be  = 4'b0000;
        hrdata   = r_hrdata;
        case (r_state)
            ST_WR_DATA: begin
                sram_req = 1'b1;
                sram_we  = 1'b1;
                sram_be  = w_be;
            end
            ST_RD_WAIT: begin
                sram_req = 1'b1;
                sram_be  = w_be;
                hreadyo  = 1'b0;
                w_next   = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                hrdata = sram_rdata;
            end
`ifdef AHB2_SRAM_SLV_ERR_EN
            ST_ERR_1: begin
                hreadyo = 1'b0;
                hresp   = HRESP_ERROR;
                w_next  = ST_ERR_2;
            end
            ST_ERR_2: begin
                hresp = HRESP_ERROR;
            end
`endif
            default: begin
            end
        endcase
        if (w_accept) begin
            w_next = w_err ? ST_ERR_1 : (hwrite ? ST_WR_DATA : ST_RD_WAIT);
        end
    end

    assign sram_addr  = r_addr;
    assign sram_wdata = hwdata;

endmodule

// File: tb/tb_ahb2_sram_slv.sv
// Self-checking bench for ahb2_sram_slv: transaction-level reference model plus directed pins.
// Honours AHB2_SRAM_SLV_ERR_EN when the design is built with it.
module tb_ahb2_sram_slv;

    localparam int MEM_AW = 12;
    localparam int DEPTH  = 1 << MEM_AW;

    // Kinds of bus cycle the model expects to see, in order, for each transfer.
    localparam int K_IDLE = 0;
    localparam int K_WR   = 1;
    localparam int K_RDW  = 2;
    localparam int K_RDD  = 3;
    localparam int K_E1   = 4;
    localparam int K_E2   = 5;

    typedef struct {
        int                kind;
        logic [MEM_AW-1:0] widx;
        logic [3:0]        be;
        logic [31:0]       wdata;
    } expRec_t;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] data;
    } req_t;

    logic              clk;
    logic              rst;
    logic              hsel;
    logic [31:0]       haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic [31:0]       hwdata;
    logic              hreadyi;
    logic [31:0]       hrdata;
    logic              hreadyo;
    logic [1:0]        hresp;
    logic              sram_req;
    logic              sram_we;
    logic [MEM_AW-1:0] sram_addr;
    logic [3:0]        sram_be;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;

    logic [31:0] sramMem [DEPTH];
    logic [31:0] refMem  [DEPTH];

    expRec_t expQ[$];
    req_t    reqQ[$];

    int nChecks = 0;
    int nFail   = 0;

    logic [31:0]       lastRd;
    logic [31:0]       obsRd;
    logic [31:0]       modelRd;
    logic [3:0]        lastWrBe;
    logic [MEM_AW-1:0] lastWrAddr;
    int                waitCnt;
    int                errCnt;
    int                reqCnt;
    int                doneCnt;
    bit                gaps;
    expRec_t           curRec;
    req_t              curReq;
    logic              curIssue;
    logic              curAccept;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ahb2_sram_slv #(.MEM_AW(MEM_AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .hsel       (hsel),
        .haddr      (haddr),
        .htrans     (htrans),
        .hwrite     (hwrite),
        .hsize      (hsize),
        .hburst     (hburst),
        .hprot      (hprot),
        .hwdata     (hwdata),
        .hreadyi    (hreadyi),
        .hrdata     (hrdata),
        .hreadyo    (hreadyo),
        .hresp      (hresp),
        .sram_req   (sram_req),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_be    (sram_be),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // Synchronous SRAM: read data appears one cycle after the strobe.
    always @(posedge clk) begin
        if (sram_req) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_be[b]) sramMem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
                end
            end else begin
                sram_rdata <= sramMem[sram_addr];
            end
        end
    end

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] calcBe(input logic [2:0] size, input logic [1:0] lo);
        if (size == 3'd0) return 4'b0001 << lo;
        if (size == 3'd1) return lo[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    // Translate an accepted transfer into the bus cycles it must produce.
    task automatic pushRecords(input req_t r);
        expRec_t e;
        logic    bad;
        bad = 1'b0;
`ifdef AHB2_SRAM_SLV_ERR_EN
        bad = (r.size > 3'd2) || ((r.size == 3'd1) && r.addr[0]) ||
              ((r.size == 3'd2) && (r.addr[1:0] != 2'b00)) || (r.addr[31:MEM_AW+2] != '0);
`endif
        e.widx  = r.addr[MEM_AW+1:2];
        e.be    = r.wr ? calcBe(r.size, r.addr[1:0]) : 4'b1111;
        e.wdata = r.data;
        if (bad) begin
            e.kind = K_E1; expQ.push_back(e);
            e.kind = K_E2; expQ.push_back(e);
        end else if (r.wr) begin
            e.kind = K_WR; expQ.push_back(e);
        end else begin
            e.kind = K_RDW; expQ.push_back(e);
            e.kind = K_RDD; expQ.push_back(e);
        end
    endtask

    task automatic addReq(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] d);
        req_t r;
        r.addr = a;
        r.wr   = w;
        r.size = s;
        r.data = d;
        reqQ.push_back(r);
    endtask

    task automatic applyStimulus();
        logic canIssue;
        if (expQ.size() > 0) begin
            curRec = expQ[0];
        end else begin
            curRec.kind  = K_IDLE;
            curRec.widx  = '0;
            curRec.be    = 4'b0000;
            curRec.wdata = 32'd0;
        end
        canIssue = (curRec.kind == K_IDLE) || (curRec.kind == K_WR) || (curRec.kind == K_RDD);
        hreadyi  = !((curRec.kind == K_RDW) || (curRec.kind == K_E1));
        hburst   = 3'($urandom_range(0, 7));
        hprot    = 4'($urandom_range(0, 15));
        hwdata   = (curRec.kind == K_WR) ? curRec.wdata : $urandom;
        curIssue = 1'b0;
        if (canIssue && (reqQ.size() > 0) && (!gaps || ($urandom_range(0, 3) != 0))) begin
            curReq   = reqQ.pop_front();
            curIssue = 1'b1;
            hsel     = 1'b1;
            htrans   = {1'b1, 1'($urandom_range(0, 1))};
            haddr    = curReq.addr;
            hwrite   = curReq.wr;
            hsize    = curReq.size;
        end else begin
            haddr  = $urandom;
            hwrite = 1'($urandom_range(0, 1));
            hsize  = 3'($urandom_range(0, 2));
            if (!canIssue) begin
                hsel   = 1'b1;
                htrans = 2'b10;
            end else if ($urandom_range(0, 1) == 1) begin
                hsel   = 1'b0;
                htrans = 2'b10;
            end else begin
                hsel   = 1'b1;
                htrans = {1'b0, 1'($urandom_range(0, 1))};
            end
        end
        curAccept = hsel && hreadyi && htrans[1] && canIssue;
    endtask

    task automatic checkOutput();
        logic       expReady;
        logic [1:0] expResp;
        logic       expReq;
        expReady = !((curRec.kind == K_RDW) || (curRec.kind == K_E1));
        expResp  = ((curRec.kind == K_E1) || (curRec.kind == K_E2)) ? 2'b01 : 2'b00;
        expReq   = (curRec.kind == K_WR) || (curRec.kind == K_RDW);
        checkValue("hreadyo", 32'(hreadyo), 32'(expReady));
        checkValue("hresp", 32'(hresp), 32'(expResp));
        checkValue("sram_req", 32'(sram_req), 32'(expReq));
        checkValue("sram_we", 32'(sram_we), 32'(curRec.kind == K_WR));
        if (expReq) begin
            checkValue("sram_addr", 32'(sram_addr), 32'(curRec.widx));
            checkValue("sram_be", 32'(sram_be), 32'(curRec.be));
        end
        if (curRec.kind == K_WR) begin
            checkValue("sram_wdata", sram_wdata, curRec.wdata);
            for (int b = 0; b < 4; b++) begin
                if (curRec.be[b]) refMem[curRec.widx][b*8 +: 8] = curRec.wdata[b*8 +: 8];
            end
            lastWrBe   = sram_be;
            lastWrAddr = sram_addr;
            doneCnt++;
        end
        if (curRec.kind == K_RDD) begin
            lastRd  = refMem[curRec.widx];
            modelRd = lastRd;
            obsRd   = hrdata;
            doneCnt++;
        end
        checkValue("hrdata", hrdata, lastRd);
        if (!hreadyo) waitCnt++;
        if (hresp == 2'b01) errCnt++;
        if (sram_req) reqCnt++;
    endtask

    task automatic oneCycle();
        applyStimulus();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
        if (expQ.size() > 0) expQ.delete(0);
        if (curAccept) pushRecords(curReq);
    endtask

    task automatic runQueue(input int budget);
        int n;
        n = 0;
        while (((reqQ.size() > 0) || (expQ.size() > 0)) && (n < budget)) begin
            oneCycle();
            n++;
        end
        if ((reqQ.size() > 0) || (expQ.size() > 0)) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL timeout: %0d requests and %0d cycles still pending after %0d cycles",
                     reqQ.size(), expQ.size(), budget);
            reqQ.delete();
            expQ.delete();
        end
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] a;
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            sramMem[i] = v;
            refMem[i]  = v;
        end
        sram_rdata = 32'd0;
        rst     = 1'b1;
        hsel    = 1'b0;
        haddr   = 32'd0;
        htrans  = 2'b00;
        hwrite  = 1'b0;
        hsize   = 3'd0;
        hburst  = 3'd0;
        hprot   = 4'd0;
        hwdata  = 32'd0;
        hreadyi = 1'b1;
        lastRd  = 32'd0;
        obsRd   = 32'd0;
        modelRd = 32'd0;
        gaps    = 1'b0;
        waitCnt = 0;
        errCnt  = 0;
        reqCnt  = 0;
        doneCnt = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkValue("rst_hreadyo", 32'(hreadyo), 32'd1);
        checkValue("rst_hresp", 32'(hresp), 32'd0);
        checkValue("rst_hrdata", hrdata, 32'd0);
        checkValue("rst_sram_req", 32'(sram_req), 32'd0);
        checkValue("rst_sram_we", 32'(sram_we), 32'd0);
        checkValue("rst_sram_be", 32'(sram_be), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] directed single write and read");
        waitCnt = 0;
        addReq(32'h0000_0010, 1'b1, 3'd2, 32'hDEADBEEF);
        runQueue(20);
        checkValue("pin_wr_addr", 32'(lastWrAddr), 32'd4);
        checkValue("pin_wr_be", 32'(lastWrBe), 32'hF);
        checkValue("pin_wr_waits", waitCnt, 32'd0);
        waitCnt = 0;
        addReq(32'h0000_0010, 1'b0, 3'd2, 32'd0);
        runQueue(20);
        checkValue("pin_rd_data", obsRd, 32'hDEADBEEF);
        checkValue("pin_rd_model", modelRd, 32'hDEADBEEF);
        checkValue("pin_rd_waits", waitCnt, 32'd1);

        $display("[TB] directed byte write merge");
        addReq(32'h0000_0013, 1'b1, 3'd0, 32'hA5A5A5A5);
        runQueue(20);
        checkValue("pin_byte_be", 32'(lastWrBe), 32'h8);
        addReq(32'h0000_0010, 1'b0, 3'd2, 32'd0);
        runQueue(20);
        checkValue("pin_merge_data", obsRd, 32'hA5ADBEEF);
        checkValue("pin_merge_model", modelRd, 32'hA5ADBEEF);

        $display("[TB] directed back-to-back");
        waitCnt = 0;
        doneCnt = 0;
        addReq(32'h0000_0020, 1'b1, 3'd2, 32'h12345678);
        addReq(32'h0000_0020, 1'b0, 3'd2, 32'd0);
        addReq(32'h0000_0024, 1'b1, 3'd2, 32'hCAFEF00D);
        runQueue(20);
        checkValue("pin_b2b_done", doneCnt, 32'd3);
        checkValue("pin_b2b_waits", waitCnt, 32'd1);
        checkValue("pin_b2b_rd", obsRd, 32'h12345678);

`ifdef AHB2_SRAM_SLV_ERR_EN
        $display("[TB] directed misaligned error");
        waitCnt = 0;
        errCnt  = 0;
        reqCnt  = 0;
        addReq(32'h0000_0002, 1'b0, 3'd2, 32'd0);
        runQueue(20);
        checkValue("pin_err_cycles", errCnt, 32'd2);
        checkValue("pin_err_waits", waitCnt, 32'd1);
        checkValue("pin_err_noreq", reqCnt, 32'd0);
`else
        $display("[TB] directed address aliasing");
        addReq(32'h0001_0040, 1'b1, 3'd2, 32'h5555AAAA);
        runQueue(20);
        checkValue("pin_alias_addr", 32'(lastWrAddr), 32'd16);
`endif

        $display("[TB] reset during read wait");
        addReq(32'h0000_0010, 1'b0, 3'd2, 32'd0);
        oneCycle();
        checkValue("pin_in_rd_wait", (expQ.size() > 0) ? 32'(expQ[0].kind) : 32'hFFFF_FFFF, 32'(K_RDW));
        applyStimulus();
        #2;
        rst = 1'b1;
        #1;
        checkValue("rst_mid_hreadyo", 32'(hreadyo), 32'd1);
        checkValue("rst_mid_sram_req", 32'(sram_req), 32'd0);
        checkValue("rst_mid_sram_we", 32'(sram_we), 32'd0);
        checkValue("rst_mid_hrdata", hrdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expQ.delete();
        lastRd = 32'd0;
        oneCycle();
        addReq(32'h0000_0030, 1'b1, 3'd2, 32'h0BADF00D);
        addReq(32'h0000_0030, 1'b0, 3'd2, 32'd0);
        runQueue(20);
        checkValue("pin_post_rst_rd", obsRd, 32'h0BADF00D);

        $display("[TB] randomized traffic");
        gaps = 1'b1;
        for (int i = 0; i < 400; i++) begin
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 255)) << 20);
            addReq(a, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2)),
                   $urandom);
        end
        runQueue(5000);
        repeat (3) oneCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
